core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the single-cycle RV64 datapath around its synchronous instruction and data BRAMs. It gates PC update, instruction-register capture, register-file write and data-memory read/write so that each instruction completes only after memory latency has elapsed. It sits between the decoded control signals and the state-changing enables of the datapath. It also provides run/halt control, illegal-opcode trapping and a retired-instruction counter.

Parameters:
IMEM_LAT, 1, instruction BRAM read latency in cycles (>=1)
DMEM_LAT, 1, data BRAM access latency in cycles (>=1)
WAIT_W, 3, width of internal latency counter (2^WAIT_W > max(IMEM_LAT, DMEM_LAT))
CNT_W, 32, width of instret counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
halt_req  in  1  level; requests entry to HALT at next instruction boundary
opcode  in  7  opcode of the captured instruction, valid in EXEC/MEM/WB
reg_write_dec  in  1  decoded RegWrite
mem_read_dec  in  1  decoded MemRead
mem_write_dec  in  1  decoded MemWrite
pc_en  out  1  PC register load enable (pc_next taken)
ir_en  out  1  instruction-register capture enable
rf_we  out  1  gated register-file write enable
dmem_re  out  1  gated data-memory read enable
dmem_we  out  1  gated data-memory write enable
retire  out  1  one-cycle pulse per completed instruction
state  out  3  current FSM state (encoding below)
busy  out  1  1 in FETCH/EXEC/MEM/WB
illegal  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, wait counter 0, instret 0, illegal 0. Applies mid-instruction; any in-flight access is abandoned with no write.
- States: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5; 6/7 unreachable, recover to IDLE.
- All enables are Moore/registered-state decodes; nothing is asserted outside the cases listed below.
- IDLE: run=1 and halt_req=0 -> FETCH; otherwise stay.
- FETCH: counter counts IMEM_LAT cycles. ir_en=1 only in the last FETCH cycle -> EXEC.
- EXEC: opcode is legal if it is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0011011, 0111011.
  - Illegal opcode: set illegal=1, no enables -> HALT.
  - mem_read_dec or mem_write_dec -> MEM (counter cleared).
  - Otherwise: rf_we=reg_write_dec, pc_en=1, retire=1, then boundary transition.
- MEM: lasts DMEM_LAT cycles.
  - dmem_re=mem_read_dec in every MEM cycle.
  - dmem_we=mem_write_dec in the first MEM cycle only (exactly one write per store).
  - At the last cycle: a load goes to WB. A store asserts pc_en=1, retire=1, then takes the boundary transition.
- WB: rf_we=1, pc_en=1, retire=1, then boundary transition.
- Boundary transition priority: halt_req=1 -> HALT; else run=0 -> IDLE; else FETCH.
- HALT: no enables.
  - illegal=1: stays until reset.
  - Otherwise exits to FETCH when halt_req=0 and run=1, or to IDLE when halt_req=0 and run=0.
- If mem_read_dec and mem_write_dec are both 1: treat as a load, and dmem_we=0.
- instret increments by 1 on every retire cycle and wraps from all-ones to 0.
- Latency (IMEM_LAT=DMEM_LAT=1): ALU/branch/jump 2 cycles, store 3, load 4. General case: IMEM_LAT+1, IMEM_LAT+DMEM_LAT+1, IMEM_LAT+DMEM_LAT+2.
- run/halt_req changes mid-instruction have no effect until the boundary.

Test Plan:
- Hold reset=0 for 3 cycles with run=1, then release -> during reset state=0, all outputs 0; first cycle after release state=IDLE, next cycle FETCH.
- run=1, opcode=0110011, reg_write_dec=1, defaults -> repeating FETCH,EXEC. ir_en is high in FETCH; rf_we, pc_en and retire are high in EXEC. After 10 instructions over 20 cycles, instret=10.
- opcode=0000011, mem_read_dec=1, DMEM_LAT=3 -> FETCH(1), EXEC(1), MEM(3, dmem_re high all 3 cycles), WB(rf_we=1, pc_en=1). Retire exactly once per 6 cycles.
- opcode=0100011, mem_write_dec=1, DMEM_LAT=2 -> dmem_we high for exactly 1 cycle. pc_en and retire fire at the end of the 2nd MEM cycle. rf_we is never high.
- opcode=0000000 in EXEC -> illegal=1, state=HALT, no pc_en or rf_we. It stays in HALT after run toggles; only reset clears it.
- halt_req=1 raised mid-load -> the load completes (WB retire), then HALT. Drop halt_req -> FETCH next cycle. With CNT_W=4, 17 retires -> instret=1.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV64 datapath: gates PC, IR, register-file and
// data-memory enables around synchronous BRAM latency, with run/halt control and instret.
module core_sequencer #(
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned DMEM_LAT = 1,
    parameter int unsigned WAIT_W   = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic [6:0]       opcode,
    input  logic             reg_write_dec,
    input  logic             mem_read_dec,
    input  logic             mem_write_dec,
    output logic             pc_en,
    output logic             ir_en,
    output logic             rf_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             retire,
    output logic [2:0]       state,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StMem   = 3'd3,
        StWb    = 3'd4,
        StHalt  = 3'd5
    } state_e;

    localparam logic [WAIT_W-1:0] ImemLast = WAIT_W'(IMEM_LAT - 1);
    localparam logic [WAIT_W-1:0] DmemLast = WAIT_W'(DMEM_LAT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   instret_q;
    state_e             boundary;

    function automatic logic is_legal(input logic [6:0] op);
        logic ok;
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0011011, 7'b0111011: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        rf_we     = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;

        if (halt_req) begin
            boundary = StHalt;
        end else if (!run) begin
            boundary = StIdle;
        end else begin
            boundary = StFetch;
        end

        case (state_q)
            StIdle: begin
                if (run && !halt_req) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (cnt_q == ImemLast) begin
                    ir_en   = 1'b1;
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            StExec: begin
                if (!is_legal(opcode)) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else if (mem_read_dec || mem_write_dec) begin
                    state_d = StMem;
                end else begin
                    rf_we   = reg_write_dec;
                    pc_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = boundary;
                end
            end
            StMem: begin
                dmem_re = mem_read_dec;
                // A combined read/write decode is a load; the single write lands in cycle 0.
                dmem_we = mem_write_dec && !mem_read_dec && (cnt_q == '0);
                if (cnt_q == DmemLast) begin
                    if (mem_read_dec) begin
                        state_d = StWb;
                    end else begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = boundary;
            end
            StHalt: begin
                if (!illegal_q && !halt_req) begin
                    state_d = run ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign busy    = (state_q == StFetch) || (state_q == StExec) ||
                     (state_q == StMem) || (state_q == StWb);
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
